// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue
//   Instruction-fetch front end. Owns the PC, addresses a combinational
//   instruction ROM, and buffers fetched words with their addresses in a
//   DEPTH-entry FIFO. The IF/ID register drains the FIFO through out_valid/out_ready.
//   A taken branch (redirect) reloads the PC and discards every buffered entry.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   fetch_en     fetch allowed this cycle
//   rom_addr     current PC, drives the ROM address
//   rom_data     ROM word at rom_addr, same cycle
//   redirect     branch taken: load redirect_pc and flush
//   redirect_pc  branch target address
//   out_valid    head entry available (masked while redirect is high)
//   out_ready    IF/ID accepts the head entry
//   out_instr    head instruction word
//   out_pc       address of the head instruction
//   out_next_pc  out_pc + PC_INC, wrapping at 2^PC_W
//   count        number of occupied entries, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
module if_prefetch_queue #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int PC_INC   = 4,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  output logic [PC_W-1:0]        rom_addr,
  input  logic [INSTR_W-1:0]     rom_data,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [PC_W-1:0]        out_next_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] PC_RST   = PC_W'(RESET_PC);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PC_W-1:0]    pc_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;

  // Entry storage: instruction word plus the address it was fetched from.
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];

  logic push;
  logic pop;

  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Redirect masks valid combinationally so IF/ID never takes a stale word
  // in the same cycle the queue is being flushed.
  assign out_valid = ~empty & ~redirect;
  assign pop       = out_valid & out_ready;
  // A full queue may still accept a word when the head leaves this cycle.
  assign push      = fetch_en & ~redirect & (~full | pop);

  assign rom_addr    = pc_reg;
  assign out_instr   = instr_mem[rd_ptr_reg];
  assign out_pc      = pc_mem[rd_ptr_reg];
  assign out_next_pc = pc_mem[rd_ptr_reg] + PC_STEP;

  // Control state. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg     <= PC_RST;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect) begin
      pc_reg     <= redirect_pc;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        pc_reg     <= pc_reg + PC_STEP;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage has no reset; entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      instr_mem[wr_ptr_reg] <= rom_data;
      pc_mem[wr_ptr_reg]    <= pc_reg;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue
//   Directed bench for if_prefetch_queue (default parameters). Inputs are
//   driven and outputs checked 1 time unit after each rising edge.
module tb_if_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [7:0]  out_next_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int vectors;
  int miscompares;

  if_prefetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_next_pc (out_next_pc),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // Combinational ROM: distinct, address-derived word per location.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  assign rom_data = rom_word(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_addr;
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || rom_addr !== 8'd0) begin
      $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b addr=%0d, want 0 1 0 0 0",
               count, empty, full, out_valid, rom_addr);
      miscompares++;
    end
    reset = 1'b1;
    #1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_addr = (i <= 4) ? 8'(4 * i) : 8'd16;
      vectors++;
      if (rom_addr !== exp_addr || count !== 3'(i <= 4 ? i : 4)) begin
        $display("FAIL fill_%0d: addr=%0d count=%0d, want addr=%0d count=%0d",
                 i, rom_addr, count, exp_addr, (i <= 4 ? i : 4));
        miscompares++;
      end
      $display("T1 fill cycle %0d addr=%0d count=%0d", i, rom_addr, count);
    end
    vectors++;
    if (full !== 1'b1 || out_valid !== 1'b1) begin
      $display("FAIL fill_full: full=%b valid=%b, want 1 1", full, out_valid);
      miscompares++;
    end
  endtask

  task automatic test_drain_order();
    logic [7:0] exp_pc;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_pc = 8'(4 * i);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== rom_word(exp_pc) ||
          out_next_pc !== exp_pc + 8'd4 || count !== 3'd4) begin
        $display("FAIL drain_%0d: valid=%b pc=%0d instr=%h next=%0d count=%0d, want 1 %0d %h %0d 4",
                 i, out_valid, out_pc, out_instr, out_next_pc, count, exp_pc, rom_word(exp_pc), exp_pc + 8'd4);
        miscompares++;
      end
      $display("T2 pop pc=%0d instr=%h", out_pc, out_instr);
      tick();
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_head;
    logic       rdy_seq [4];
    rdy_seq[0] = 1'b1; rdy_seq[1] = 1'b0; rdy_seq[2] = 1'b0; rdy_seq[3] = 1'b1;
    exp_head = 8'd24;
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy_seq[i];
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== exp_head || out_instr !== rom_word(exp_head) || count !== 3'd4) begin
        $display("FAIL stall_%0d: valid=%b pc=%0d instr=%h count=%0d, want 1 %0d %h 4",
                 i, out_valid, out_pc, out_instr, count, exp_head, rom_word(exp_head));
        miscompares++;
      end
      $display("T3 ready=%b head pc=%0d", out_ready, out_pc);
      if (rdy_seq[i]) exp_head = exp_head + 8'd4;
      tick();
    end
    // Next head after two accepted entries.
    vectors++;
    if (out_pc !== 8'd32 || rom_addr !== 8'd48) begin
      $display("FAIL stall_end: pc=%0d addr=%0d, want 32 48", out_pc, rom_addr);
      miscompares++;
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 8'h40; out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      $display("FAIL redirect_mask: valid=%b, want 0", out_valid);
      miscompares++;
    end
    tick();
    redirect = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || rom_addr !== 8'h40 || out_valid !== 1'b0) begin
      $display("FAIL redirect_flush: count=%0d empty=%b addr=%h valid=%b, want 0 1 40 0",
               count, empty, rom_addr, out_valid);
      miscompares++;
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_next_pc !== 8'h44 || out_instr !== rom_word(8'h40)) begin
      $display("FAIL redirect_first: valid=%b pc=%h next=%h instr=%h, want 1 40 44 %h",
               out_valid, out_pc, out_next_pc, out_instr, rom_word(8'h40));
      miscompares++;
    end
    $display("T4 first after redirect pc=%h next=%h", out_pc, out_next_pc);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    redirect = 1'b1; redirect_pc = 8'd248;
    tick();
    redirect = 1'b0;
    tick();
    exp_pc = 8'd248;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_next_pc !== exp_pc + 8'd4 ||
          out_instr !== rom_word(exp_pc) || count !== 3'd1) begin
        $display("FAIL wrap_%0d: valid=%b pc=%0d next=%0d instr=%h count=%0d, want 1 %0d %0d %h 1",
                 i, out_valid, out_pc, out_next_pc, out_instr, count, exp_pc, exp_pc + 8'd4, rom_word(exp_pc));
        miscompares++;
      end
      $display("T5 pop pc=%0d next=%0d", out_pc, out_next_pc);
      exp_pc = exp_pc + 8'd4;
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (count !== 3'd3) begin
      $display("FAIL midreset_pre: count=%0d, want 3", count);
      miscompares++;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || rom_addr !== 8'd0) begin
      $display("FAIL midreset_post: count=%0d valid=%b addr=%0d, want 0 0 0", count, out_valid, rom_addr);
      miscompares++;
    end
    tick();
    vectors++;
    if (count !== 3'd1 || out_pc !== 8'd0 || out_instr !== rom_word(8'd0) || rom_addr !== 8'd4) begin
      $display("FAIL midreset_refill: count=%0d pc=%0d instr=%h addr=%0d, want 1 0 %h 4",
               count, out_pc, out_instr, rom_addr, rom_word(8'd0));
      miscompares++;
    end
    $display("T6 refill head pc=%0d count=%0d", out_pc, count);
  endtask

  task automatic test_fetch_hold();
    fetch_en = 1'b0; out_ready = 1'b1;
    #1;
    tick();
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || rom_addr !== 8'd4) begin
      $display("FAIL hold_pop: count=%0d empty=%b addr=%0d, want 0 1 4", count, empty, rom_addr);
      miscompares++;
    end
    tick();
    vectors++;
    if (count !== 3'd0 || rom_addr !== 8'd4 || out_valid !== 1'b0) begin
      $display("FAIL hold_idle: count=%0d addr=%0d valid=%b, want 0 4 0", count, rom_addr, out_valid);
      miscompares++;
    end
    $display("T7 fetch disabled addr=%0d count=%0d", rom_addr, count);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_drain_order();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_op();
    test_fetch_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
